// File: rtl/rv32imf_wb_arbiter.sv
// rv32imf_wb_arbiter: round-robin write-back arbiter feeding a dual-write-port
// 64-entry register file (addr bit 5 selects the FP bank).
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   hold_i              blocks every grant (debug halt / flush)
//   req_valid_i         per-requester write request (0 ALU, 1 LSU, 2 MULDIV, 3 FPU)
//   req_ready_o         per-requester accept, combinational
//   req_addr_i          packed destination addresses, requester i in slice i
//   req_data_i          packed write data, requester i in slice i
//   we_a_o/waddr_a_o/wdata_a_o   registered write port A
//   we_b_o/waddr_b_o/wdata_b_o   registered write port B
//   pending_o           per-register "write in output stage" mask
module rv32imf_wb_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            hold_i,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    output logic [NUM_REQ-1:0]              req_ready_o,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data_i,
    output logic                            we_a_o,
    output logic [ADDR_WIDTH-1:0]           waddr_a_o,
    output logic [DATA_WIDTH-1:0]           wdata_a_o,
    output logic                            we_b_o,
    output logic [ADDR_WIDTH-1:0]           waddr_b_o,
    output logic [DATA_WIDTH-1:0]           wdata_b_o,
    output logic [2**ADDR_WIDTH-1:0]        pending_o
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0]         rr_ptr;
    logic [PW-1:0]         rr_next;
    logic [PW-1:0]         idx;
    logic [PW-1:0]         a_idx;
    logic [PW-1:0]         b_idx;
    logic [PW-1:0]         last_idx;
    logic                  a_hit;
    logic                  b_hit;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] a_data;
    logic [DATA_WIDTH-1:0] b_data;

    // Scan requesters starting at rr_ptr. x0 writes are accepted and dropped;
    // a request matching slot A's address is skipped without blocking slot B.
    always_comb begin
        req_ready_o = '0;
        a_hit       = 1'b0;
        b_hit       = 1'b0;
        a_idx       = '0;
        b_idx       = '0;
        a_addr      = '0;
        b_addr      = '0;
        a_data      = '0;
        b_data      = '0;
        idx         = '0;
        cur_addr    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx      = PW'((int'(rr_ptr) + k) % NUM_REQ);
            cur_addr = req_addr_i[idx*ADDR_WIDTH +: ADDR_WIDTH];
            if (rst_n && !hold_i && req_valid_i[idx]) begin
                if (cur_addr == '0) begin
                    req_ready_o[idx] = 1'b1;
                end else if (!a_hit) begin
                    a_hit            = 1'b1;
                    a_idx            = idx;
                    a_addr           = cur_addr;
                    a_data           = req_data_i[idx*DATA_WIDTH +: DATA_WIDTH];
                    req_ready_o[idx] = 1'b1;
                end else if (!b_hit && cur_addr != a_addr) begin
                    b_hit            = 1'b1;
                    b_idx            = idx;
                    b_addr           = cur_addr;
                    b_data           = req_data_i[idx*DATA_WIDTH +: DATA_WIDTH];
                    req_ready_o[idx] = 1'b1;
                end
            end
        end
    end

    // Slot B is always later in scan order than slot A, so it is the last grant.
    always_comb begin
        last_idx = b_hit ? b_idx : a_idx;
        if (last_idx == PW'(NUM_REQ - 1)) begin
            rr_next = '0;
        end else begin
            rr_next = last_idx + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            we_a_o    <= 1'b0;
            we_b_o    <= 1'b0;
            waddr_a_o <= '0;
            waddr_b_o <= '0;
            wdata_a_o <= '0;
            wdata_b_o <= '0;
        end else begin
            we_a_o <= a_hit;
            we_b_o <= b_hit;
            if (a_hit) begin
                rr_ptr    <= rr_next;
                waddr_a_o <= a_addr;
                wdata_a_o <= a_data;
            end
            if (b_hit) begin
                waddr_b_o <= b_addr;
                wdata_b_o <= b_data;
            end
        end
    end

    always_comb begin
        pending_o = '0;
        if (we_a_o) pending_o[waddr_a_o] = 1'b1;
        if (we_b_o) pending_o[waddr_b_o] = 1'b1;
        pending_o[0] = 1'b0;
    end

endmodule

// File: doc/rv32imf_wb_arbiter.md
Name: rv32imf_wb_arbiter

Overview:
Write-back arbiter in front of the dual-write-port integer/FP register file (64 entries: bit 5 of the address selects the FP bank). It accepts result write requests from up to NUM_REQ functional units (ALU, LSU, MUL/DIV, FPU) over valid/ready handshakes. Each cycle it grants up to two requests onto write ports A/B using round-robin priority. It registers the port drive and exports a pending-write mask for decode hazard checks.

Parameters:
NUM_REQ, 4, number of requesters; index 0 = ALU, 1 = LSU, 2 = MULDIV, 3 = FPU.
ADDR_WIDTH, 6, register file address width; bit 5 = FP bank.
DATA_WIDTH, 32, write data width.

Ports:
clk  input  1  clock.
rst_n  input  1  reset, asynchronous, active-low.
hold_i  input  1  when high, block all grants (debug halt/flush).
req_valid_i  input  NUM_REQ  per-requester write request.
req_ready_o  output  NUM_REQ  per-requester accept; handshake = valid & ready.
req_addr_i  input  NUM_REQ*ADDR_WIDTH  packed destination addresses; requester i in slice i.
req_data_i  input  NUM_REQ*DATA_WIDTH  packed write data.
we_a_o  output  1  write enable, port A.
waddr_a_o  output  ADDR_WIDTH  write address, port A.
wdata_a_o  output  DATA_WIDTH  write data, port A.
we_b_o  output  1  write enable, port B.
waddr_b_o  output  ADDR_WIDTH  write address, port B.
wdata_b_o  output  DATA_WIDTH  write data, port B.
pending_o  output  2**ADDR_WIDTH  per-register "write in output stage" mask.

Behaviour:
- Reset (async assert, sync deassert effect): we_a_o = we_b_o = 0; waddr/wdata outputs = 0; rr_ptr = 0; pending_o = 0. req_ready_o is combinational and is 0 while the outputs are in reset.
- req_ready_o depends only on req_valid_i, req_addr_i, hold_i and rr_ptr. It never depends on another requester's ready.
- hold_i = 1: all req_ready_o = 0 and no grants. Registered outputs take the no-grant value on the next edge.
- Grant scan each cycle, hold_i = 0, requesters visited in the order rr_ptr, rr_ptr+1, ... mod NUM_REQ:
  - A valid request with addr == 0 (x0) gets ready = 1. It is discarded and uses no port.
  - The first valid request with nonzero addr is slot A.
  - The next valid request with nonzero addr different from slot A's addr is slot B.
  - A request with the same addr as slot A is not granted this cycle and does not block later requesters from slot B.
  - All other requests: ready = 0 and must hold stable.
- Output stage, registered, updated every edge:
  - we_a_o <= slot A granted; on grant, waddr_a_o/wdata_a_o <= slot A addr/data.
  - Port B behaves the same way with slot B.
  - When not granted, addr/data hold their previous values and only we drops.
- Latency: handshake in cycle N -> we asserted in cycle N+1 -> register file updated at the end of N+1.
- Port A and port B never carry the same address with both enables high.
- rr_ptr update: if any port grant occurs, rr_ptr <= (index of the last port-granted requester + 1) mod NUM_REQ. Otherwise unchanged; x0-only accepts do not move it.
- pending_o[k] = (we_a_o & waddr_a_o == k) | (we_b_o & waddr_b_o == k). pending_o[0] is always 0.
- Back-to-back grants are allowed every cycle; no bubbles are inserted.
- Reset mid-operation: outputs and rr_ptr clear immediately. Any in-flight write is lost; requesters must reissue.
- Worst-case wait for a valid requester: ceil(NUM_REQ/2) grant cycles when no same-address conflict exists.

Test Plan:
1. Reset -> we_a_o = we_b_o = 0, pending_o = 0, req_ready_o = 0000 while rst_n = 0. After release, one request at req0 addr 1 -> ready = 0001.
2. All four valid at rr_ptr = 0, addrs 1, 2, 3, 33, held until accepted:
   - cycle 0: ready = 0011.
   - cycle 1: we_a addr 1, we_b addr 2; ready = 1100; rr_ptr = 2.
   - cycle 2: we_a addr 3, we_b addr 33; pending_o bits 3 and 33 set.
3. req0 addr 5 data 0xAAAA_AAAA and req1 addr 5 data 0x5555_5555, rr_ptr = 0:
   - cycle 0: only req0 ready; cycle 1: port A = 0xAAAA_AAAA, we_b = 0.
   - req1 is granted in cycle 1 and drives port A in cycle 2.
4. req0 addr 7, req1 addr 0, req2 addr 8, rr_ptr = 0 -> ready = 0111. Next cycle port A addr 7, port B addr 8; no write to addr 0; rr_ptr = 3.
5. All four valid with hold_i = 1 for 3 cycles -> ready = 0000 and we low throughout. On hold_i falling, grants resume from the unchanged rr_ptr.
6. Assert rst_n low mid-cycle while we_a_o = 1, addr 9 -> we_a_o and pending_o[9] drop immediately, without waiting for a clock edge.
